// File: rtl/bp_cfg_link_pkg.sv
// bp_cfg_link_pkg: shared widths, register map and command/response types for the cfg link responder.
package bp_cfg_link_pkg;
  localparam int cfg_core_width_lp = 8;
  localparam int cfg_addr_width_lp = 16;
  localparam int cfg_data_width_lp = 32;
  localparam int vaddr_width_lp    = 39;
  localparam logic [cfg_core_width_lp-1:0] cfg_bcast_id_lp = '1;
  typedef enum logic [cfg_addr_width_lp-1:0] {
    e_cfg_freeze  = 16'h0001,
    e_cfg_icache  = 16'h0002,
    e_cfg_dcache  = 16'h0003,
    e_cfg_cce     = 16'h0004,
    e_cfg_npc_lo  = 16'h0010,
    e_cfg_npc_hi  = 16'h0011
  } bp_cfg_addr_e;
  typedef struct packed {
    logic [cfg_core_width_lp-1:0] core_id;
    logic [cfg_addr_width_lp-1:0] addr;
    logic                         we;
    logic [cfg_data_width_lp-1:0] data;
  } bp_cfg_cmd_s;
  typedef struct packed {
    logic                         err;
    logic [cfg_data_width_lp-1:0] data;
  } bp_cfg_resp_s;
endpackage

// File: rtl/bsg_dff_reset_en.sv
// bsg_dff_reset_en: enabled register with synchronous active-high reset to a parameterised value.
module bsg_dff_reset_en #(
  parameter int                 width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);
  always_ff @(posedge clk_i)
    if (reset_i) data_o <= reset_val_p;
    else if (en_i) data_o <= data_i;
endmodule

// File: rtl/bp_cfg_link_responder.sv
// bp_cfg_link_responder: per-tile cfg link endpoint holding freeze, cache/CCE modes and NPC.
module bp_cfg_link_responder
  import bp_cfg_link_pkg::*;
#(
  parameter int cfg_core_width_p = cfg_core_width_lp,
  parameter int cfg_addr_width_p = cfg_addr_width_lp,
  parameter int cfg_data_width_p = cfg_data_width_lp,
  parameter int vaddr_width_p    = vaddr_width_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [cfg_core_width_p-1:0] my_core_id_i,
  input  logic                        cmd_v_i,
  output logic                        cmd_ready_o,
  input  logic [cfg_core_width_p-1:0] cmd_core_id_i,
  input  logic [cfg_addr_width_p-1:0] cmd_addr_i,
  input  logic                        cmd_we_i,
  input  logic [cfg_data_width_p-1:0] cmd_data_i,
  output logic                        resp_v_o,
  input  logic                        resp_ready_i,
  output logic [cfg_data_width_p-1:0] resp_data_o,
  output logic                        resp_err_o,
  output logic                        freeze_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic                        cce_mode_o,
  output logic [vaddr_width_p-1:0]    npc_o,
  output logic                        npc_w_v_o
);
  localparam int npc_hi_w_lp = vaddr_width_p - cfg_data_width_p;
  typedef enum logic {e_ready, e_resp} state_e;
  state_e state_q, state_d;
  bp_cfg_cmd_s  cmd;
  bp_cfg_resp_s resp_d, resp_q;
  logic bcast, match, hs, wr_v, rd_v, mapped;
  logic [cfg_data_width_p-1:0] rd_data;
  logic [cfg_data_width_p-1:0] npc_lo_q;
  logic [npc_hi_w_lp-1:0]      npc_hi_q;
  assign cmd   = '{core_id: cmd_core_id_i, addr: cmd_addr_i, we: cmd_we_i, data: cmd_data_i};
  assign bcast = (cmd.core_id == cfg_bcast_id_lp);
  assign match = bcast | (cmd.core_id == my_core_id_i);
  assign hs    = cmd_v_i & (state_q == e_ready) & ~reset_i;
  assign wr_v  = hs & match & cmd.we;
  assign rd_v  = hs & match & ~cmd.we;
  always_ff @(posedge clk_i) state_q <= reset_i ? e_ready : state_d;
  always_comb begin
    cmd_ready_o = (state_q == e_ready) & ~reset_i;
    resp_v_o    = (state_q == e_resp);
    state_d     = rd_v ? e_resp : (resp_v_o & resp_ready_i) ? e_ready : state_q;
  end
  // Broadcast reads are rejected: every tile would answer on the shared link.
  always_comb begin
    mapped = cmd.addr inside {e_cfg_freeze, e_cfg_icache, e_cfg_dcache, e_cfg_cce, e_cfg_npc_lo, e_cfg_npc_hi};
    rd_data = (cmd.addr == e_cfg_freeze) ? cfg_data_width_p'(freeze_o)
            : (cmd.addr == e_cfg_icache) ? cfg_data_width_p'(icache_mode_o)
            : (cmd.addr == e_cfg_dcache) ? cfg_data_width_p'(dcache_mode_o)
            : (cmd.addr == e_cfg_cce)    ? cfg_data_width_p'(cce_mode_o)
            : (cmd.addr == e_cfg_npc_lo) ? npc_lo_q
            : (cmd.addr == e_cfg_npc_hi) ? cfg_data_width_p'(npc_hi_q)
            : '0;
    resp_d.err  = bcast | ~mapped;
    resp_d.data = resp_d.err ? '0 : rd_data;
  end
  bsg_dff_reset_en #(.width_p($bits(bp_cfg_resp_s))) resp_reg (
    .clk_i, .reset_i, .en_i(rd_v), .data_i(resp_d), .data_o(resp_q));
  bsg_dff_reset_en #(.width_p(1), .reset_val_p(1'b1)) freeze_reg (
    .clk_i, .reset_i, .en_i(wr_v & (cmd.addr == e_cfg_freeze)), .data_i(cmd.data[0]), .data_o(freeze_o));
  bsg_dff_reset_en #(.width_p(2)) icache_reg (
    .clk_i, .reset_i, .en_i(wr_v & (cmd.addr == e_cfg_icache)), .data_i(cmd.data[1:0]), .data_o(icache_mode_o));
  bsg_dff_reset_en #(.width_p(2)) dcache_reg (
    .clk_i, .reset_i, .en_i(wr_v & (cmd.addr == e_cfg_dcache)), .data_i(cmd.data[1:0]), .data_o(dcache_mode_o));
  bsg_dff_reset_en #(.width_p(1)) cce_reg (
    .clk_i, .reset_i, .en_i(wr_v & (cmd.addr == e_cfg_cce)), .data_i(cmd.data[0]), .data_o(cce_mode_o));
  bsg_dff_reset_en #(.width_p(cfg_data_width_p)) npc_lo_reg (
    .clk_i, .reset_i, .en_i(wr_v & (cmd.addr == e_cfg_npc_lo)), .data_i(cmd.data), .data_o(npc_lo_q));
  bsg_dff_reset_en #(.width_p(npc_hi_w_lp)) npc_hi_reg (
    .clk_i, .reset_i, .en_i(wr_v & (cmd.addr == e_cfg_npc_hi)), .data_i(cmd.data[npc_hi_w_lp-1:0]), .data_o(npc_hi_q));
  // The high-half write completes the NPC, so it alone raises the pulse.
  bsg_dff_reset_en #(.width_p(1)) npc_w_v_reg (
    .clk_i, .reset_i, .en_i(1'b1), .data_i(wr_v & (cmd.addr == e_cfg_npc_hi)), .data_o(npc_w_v_o));
  assign npc_o       = {npc_hi_q, npc_lo_q};
  assign resp_data_o = resp_q.data;
  assign resp_err_o  = resp_q.err;
endmodule

// File: tb/tb_bp_cfg_link_responder.sv
// tb_bp_cfg_link_responder: scoreboard-driven checks of cfg register writes, reads, errors and reset.
module tb_bp_cfg_link_responder;
  logic clk = 0;
  always #5 clk = ~clk;
  logic        reset, cmd_v, cmd_ready, cmd_we, resp_v, resp_ready, resp_err;
  logic        freeze, cce_mode, npc_w_v;
  logic [1:0]  icache_mode, dcache_mode;
  logic [7:0]  my_id, cmd_id;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data, resp_data;
  logic [38:0] npc;
  int vec = 0, errs = 0;
  logic [32:0] sb[$];
  bp_cfg_link_responder dut (
    .clk_i(clk), .reset_i(reset), .my_core_id_i(my_id),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_core_id_i(cmd_id), .cmd_addr_i(cmd_addr),
    .cmd_we_i(cmd_we), .cmd_data_i(cmd_data),
    .resp_v_o(resp_v), .resp_ready_i(resp_ready), .resp_data_o(resp_data), .resp_err_o(resp_err),
    .freeze_o(freeze), .icache_mode_o(icache_mode), .dcache_mode_o(dcache_mode),
    .cce_mode_o(cce_mode), .npc_o(npc), .npc_w_v_o(npc_w_v));
  task automatic send(input logic [7:0] id, input logic [15:0] a, input logic we, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cmd_v = 1; cmd_id = id; cmd_addr = a; cmd_we = we; cmd_data = d;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    vec++;
    if (cmd_ready !== 1'b1) begin errs++; $display("FAIL send_ready got=%b want=1", cmd_ready); end
    @(posedge clk); #1;
    cmd_v = 0;
    if (!we) sb.push_back({1'b0, 32'h0});
  endtask
  task automatic expect_read(input logic err, input logic [31:0] d);
    void'(sb.pop_back());
    sb.push_back({err, d});
  endtask
  task automatic drain(output logic [32:0] r, output logic timeout);
    int n = 0;
    while (!resp_v && n < 20) begin @(negedge clk); n++; end
    timeout = !resp_v;
    r = {resp_err, resp_data};
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({freeze, icache_mode, dcache_mode, cce_mode, npc, npc_w_v, resp_v, resp_err, resp_data, cmd_ready} !== {1'b1, 2'd0, 2'd0, 1'b0, 39'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0}) begin
      errs++; $display("FAIL reset_vals got fz=%b ic=%0d dc=%0d cce=%b npc=%h pulse=%b rv=%b err=%b rd=%h rdy=%b", freeze, icache_mode, dcache_mode, cce_mode, npc, npc_w_v, resp_v, resp_err, resp_data, cmd_ready);
    end
    @(negedge clk); reset = 0;
    @(negedge clk);
    vec++;
    if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
  endtask
  task automatic test_npc_freeze;
    send(8'd3, 16'h0010, 1, 32'h8000_0000);
    vec++;
    if (npc !== 39'h00_8000_0000 || npc_w_v !== 1'b0) begin errs++; $display("FAIL npc_lo got npc=%h pulse=%b want 0080000000/0", npc, npc_w_v); end
    send(8'd3, 16'h0011, 1, 32'h0);
    vec++;
    if (npc !== 39'h00_8000_0000 || npc_w_v !== 1'b1) begin errs++; $display("FAIL npc_hi got npc=%h pulse=%b want 0080000000/1", npc, npc_w_v); end
    @(posedge clk); #1;
    vec++;
    if (npc_w_v !== 1'b0) begin errs++; $display("FAIL npc_pulse_len got=%b want=0", npc_w_v); end
    send(8'd3, 16'h0011, 1, 32'hFFFF_FF05);
    vec++;
    if (npc !== 39'h05_8000_0000) begin errs++; $display("FAIL npc_hi_trunc got=%h want=0580000000", npc); end
    send(8'd3, 16'h0001, 1, 32'h0);
    vec++;
    if (freeze !== 1'b0) begin errs++; $display("FAIL freeze_clr got=%b want=0", freeze); end
  endtask
  task automatic test_read_hold;
    logic [32:0] r, want;
    logic to;
    send(8'd3, 16'h0002, 1, 32'd2);
    vec++;
    if (icache_mode !== 2'd2) begin errs++; $display("FAIL icache_wr got=%0d want=2", icache_mode); end
    send(8'd3, 16'h0002, 0, 0);
    expect_read(1'b0, 32'd2);
    vec++;
    if (resp_v !== 1'b1) begin errs++; $display("FAIL read_latency resp_v got=%b want=1", resp_v); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++;
      if (resp_v !== 1'b1 || cmd_ready !== 1'b0 || {resp_err, resp_data} !== sb[0]) begin
        errs++; $display("FAIL read_hold[%0d] got v=%b rdy=%b resp=%h want 1/0/%h", i, resp_v, cmd_ready, {resp_err, resp_data}, sb[0]);
      end
    end
    drain(r, to);
    want = sb.pop_front();
    vec++;
    if (to || r !== want) begin errs++; $display("FAIL read_icache got=%h to=%b want=%h", r, to, want); end
    vec++;
    if (resp_v !== 1'b0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL read_release got v=%b rdy=%b want 0/1", resp_v, cmd_ready); end
  endtask
  task automatic test_broadcast;
    logic [32:0] r, want;
    logic to;
    send(8'hFF, 16'h0004, 1, 32'd1);
    vec++;
    if (cce_mode !== 1'b1) begin errs++; $display("FAIL bcast_wr got=%b want=1", cce_mode); end
    send(8'hFF, 16'h0003, 0, 0);
    expect_read(1'b1, 32'd0);
    drain(r, to);
    want = sb.pop_front();
    vec++;
    if (to || r !== want) begin errs++; $display("FAIL bcast_rd got=%h to=%b want=%h", r, to, want); end
    send(8'd5, 16'h0001, 1, 32'd1);
    vec++;
    if (freeze !== 1'b0 || resp_v !== 1'b0) begin errs++; $display("FAIL other_id_wr got fz=%b rv=%b want 0/0", freeze, resp_v); end
    send(8'd5, 16'h0002, 0, 0);
    void'(sb.pop_back());
    vec++;
    if (resp_v !== 1'b0) begin errs++; $display("FAIL other_id_rd got rv=%b want=0", resp_v); end
  endtask
  task automatic test_unmapped;
    logic [32:0] r, want;
    logic to;
    send(8'd3, 16'h0100, 0, 0);
    expect_read(1'b1, 32'd0);
    drain(r, to);
    want = sb.pop_front();
    vec++;
    if (to || r !== want) begin errs++; $display("FAIL unmapped_rd got=%h to=%b want=%h", r, to, want); end
    send(8'd3, 16'h0100, 1, 32'hFFFF_FFFF);
    vec++;
    if ({freeze, icache_mode, dcache_mode, cce_mode, npc, resp_v} !== {1'b0, 2'd2, 2'd0, 1'b1, 39'h05_8000_0000, 1'b0}) begin
      errs++; $display("FAIL unmapped_wr got fz=%b ic=%0d dc=%0d cce=%b npc=%h rv=%b", freeze, icache_mode, dcache_mode, cce_mode, npc, resp_v);
    end
  endtask
  task automatic test_back_to_back;
    logic [32:0] r, want;
    logic to;
    logic [15:0] addrs[6] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0010, 16'h0011};
    logic [31:0] vals[6]  = '{32'd0, 32'd2, 32'd3, 32'd1, 32'h8000_0000, 32'h5};
    send(8'd3, 16'h0003, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      send(8'd3, addrs[i], 0, 0);
      expect_read(1'b0, vals[i]);
      drain(r, to);
      want = sb.pop_front();
      vec++;
      if (to || r !== want) begin errs++; $display("FAIL rd_%h got=%h to=%b want=%h", addrs[i], r, to, want); end
    end
  endtask
  task automatic test_reset_mid;
    send(8'd3, 16'h0001, 0, 0);
    sb.delete();
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    vec++;
    if (resp_v !== 1'b0 || freeze !== 1'b1 || npc !== 39'd0 || cce_mode !== 1'b0 || cmd_ready !== 1'b0) begin
      errs++; $display("FAIL reset_mid got rv=%b fz=%b npc=%h cce=%b rdy=%b want 0/1/0/0/0", resp_v, freeze, npc, cce_mode, cmd_ready);
    end
    @(negedge clk); reset = 0;
    @(negedge clk);
    vec++;
    if (cmd_ready !== 1'b1 || resp_v !== 1'b0) begin errs++; $display("FAIL reset_mid_rel got rdy=%b rv=%b want 1/0", cmd_ready, resp_v); end
  endtask
  initial begin
    reset = 1; my_id = 8'd3; cmd_v = 0; cmd_id = 0; cmd_addr = 0; cmd_we = 0; cmd_data = 0; resp_ready = 0;
    test_reset;
    test_npc_freeze;
    test_read_hold;
    test_broadcast;
    test_unmapped;
    test_back_to_back;
    test_reset_mid;
    vec++;
    if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
